// File: rtl/alu_div_32bit.sv
// 32-bit restoring divider, signed/unsigned, fixed 33-cycle latency.
// Magnitudes are divided unsigned; signs are applied in a single fixup cycle.
module alu_div_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_sop;
  logic        r_neg_n;
  logic        r_neg_d;
  logic        r_dz;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [31:0] r_q_out;
  logic [31:0] r_r_out;
  logic        r_dz_out;
  logic        r_done;

  logic        w_neg_n;
  logic        w_neg_d;
  logic [31:0] w_abs_n;
  logic [31:0] w_abs_d;
  logic [32:0] w_trial;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == 6'd31) w_next = S_FIXUP;
      S_FIXUP: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_neg_n = signed_op & dividend[31];
  assign w_neg_d = signed_op & divisor[31];
  assign w_abs_n = w_neg_n ? (~dividend + 32'd1) : dividend;
  assign w_abs_d = w_neg_d ? (~divisor + 32'd1) : divisor;

  // Partial remainder stays below the divisor, so 33 bits hold the trial.
  assign w_trial = {r_rem, r_quo[31]} - {1'b0, r_dvs};

  // Zero divisor: remainder already equals |dividend|; sign restore gives the original.
  assign w_q_fix = r_dz ? 32'hFFFF_FFFF :
                   (r_sop & (r_neg_n ^ r_neg_d)) ? (~r_quo + 32'd1) : r_quo;
  assign w_r_fix = (r_sop & r_neg_n) ? (~r_rem + 32'd1) : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sop    <= 1'b0;
      r_neg_n  <= 1'b0;
      r_neg_d  <= 1'b0;
      r_dz     <= 1'b0;
      r_cnt    <= 6'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_dvs    <= 32'd0;
      r_q_out  <= 32'd0;
      r_r_out  <= 32'd0;
      r_dz_out <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sop   <= signed_op;
            r_neg_n <= w_neg_n;
            r_neg_d <= w_neg_d;
            r_dz    <= (divisor == 32'd0);
            r_cnt   <= 6'd0;
            r_rem   <= 32'd0;
            r_quo   <= w_abs_n;
            r_dvs   <= w_abs_d;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 6'd1;
          if (!w_trial[32]) r_rem <= w_trial[31:0];
          else              r_rem <= {r_rem[30:0], r_quo[31]};
          r_quo <= {r_quo[30:0], ~w_trial[32]};
        end
        S_FIXUP: begin
          r_q_out  <= w_q_fix;
          r_r_out  <= w_r_fix;
          r_dz_out <= r_dz;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_q_out;
  assign remainder   = r_r_out;
  assign div_by_zero = r_dz_out;
  assign done        = r_done;
  assign busy        = (r_state != S_IDLE);

endmodule
